// File: rtl/day3_pipelined_adder.sv
// -----------------------------------------------------------------------------
// day3_pipelined_adder
//
// Purpose
//   WIDTH-bit unsigned adder with its carry chain cut into STAGES registered
//   chunks of CHUNK = WIDTH/STAGES bits. Stage k adds chunk k of the operands
//   plus the carry registered by stage k-1, appends the result to the partial
//   sum and forwards the operand bits that have not been added yet.
//   Operands enter and results leave through valid/ready handshakes. The whole
//   pipeline advances together, so throughput is one beat per cycle and the
//   latency is STAGES cycles when the output is not stalled.
//
// Parameters
//   WIDTH   operand/sum width in bits (default 16)
//   STAGES  pipeline depth; WIDTH must be a multiple of STAGES (default 4)
//
// Optional feature
//   PIPE_ADDER_SUB_EN  when defined, adds input sub_i. sub_i=1 inverts B, so
//                      with cin_i=1 the block computes A-B and cout_o=1 means
//                      "no borrow". When undefined the block always adds.
//
// Ports
//   clk_i        in   1      clock, rising edge
//   resetn_i     in   1      synchronous reset, active-low
//   in_valid_i   in   1      operand beat valid
//   in_ready_o   out  1      block can accept an operand beat
//   a_i          in   WIDTH  operand A
//   b_i          in   WIDTH  operand B
//   cin_i        in   1      carry-in to bit 0
//   sub_i        in   1      subtract select (PIPE_ADDER_SUB_EN only)
//   out_valid_o  out  1      result beat valid
//   out_ready_i  in   1      downstream accepts the result
//   sum_o        out  WIDTH  result sum
//   cout_o       out  1      carry-out of bit WIDTH-1
// -----------------------------------------------------------------------------
module day3_pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_cfg_check
        $error("day3_pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    // One enable for every stage: the pipeline moves only when the output
    // register is empty or is being drained this cycle. Bubbles move with it.
    logic w_en;

    assign w_en       = !out_valid_o || out_ready_i;
    assign in_ready_o = w_en && resetn_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Sum bits resolved once this stage has registered its chunk.
        localparam int DONE  = (k + 1) * CHUNK;
        // Operand bits still unadded when a beat arrives at this stage.
        localparam int SRC_W = WIDTH - k * CHUNK;

        logic             w_valid_in;
        logic [SRC_W-1:0] w_a_src;
        logic [SRC_W-1:0] w_b_src;
        logic             w_c_in;
        logic [DONE-1:0]  w_sum_next;
        logic [CHUNK-1:0] w_b_chunk;
        logic [CHUNK:0]   w_chunk_sum;
`ifdef PIPE_ADDER_SUB_EN
        logic             w_sub_in;
`endif

        logic             r_valid;
        logic [DONE-1:0]  r_sum;
        logic             r_cout;

        // Source of this stage: the input ports for stage 0, otherwise the
        // registers of the previous stage.
        if (k == 0) begin : g_head
            assign w_valid_in = in_valid_i;
            assign w_a_src    = a_i;
            assign w_b_src    = b_i;
            assign w_c_in     = cin_i;
            assign w_sum_next = w_chunk_sum[CHUNK-1:0];
`ifdef PIPE_ADDER_SUB_EN
            assign w_sub_in   = sub_i;
`endif
        end else begin : g_body
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_a_src    = g_stage[k-1].g_fwd.r_a;
            assign w_b_src    = g_stage[k-1].g_fwd.r_b;
            assign w_c_in     = g_stage[k-1].r_cout;
            // New chunk lands above the chunks already resolved upstream.
            assign w_sum_next = {w_chunk_sum[CHUNK-1:0], g_stage[k-1].r_sum};
`ifdef PIPE_ADDER_SUB_EN
            assign w_sub_in   = g_stage[k-1].g_fwd.r_sub;
`endif
        end

        // The lowest CHUNK bits of the forwarded operands are always the
        // chunk this stage is responsible for.
`ifdef PIPE_ADDER_SUB_EN
        assign w_b_chunk = w_b_src[CHUNK-1:0] ^ {CHUNK{w_sub_in}};
`else
        assign w_b_chunk = w_b_src[CHUNK-1:0];
`endif

        assign w_chunk_sum = {1'b0, w_a_src[CHUNK-1:0]}
                           + {1'b0, w_b_chunk}
                           + {{CHUNK{1'b0}}, w_c_in};

        // NOTE: all state is written with non-blocking assignments so every
        // stage samples the pre-edge value of its upstream neighbour.
        always_ff @(posedge clk_i) begin
            if (!resetn_i) begin
                r_valid <= 1'b0;
            end else if (w_en) begin
                r_valid <= w_valid_in;
            end
        end

        // NOTE: only the valid bits and the output-facing data register are
        // reset. Inner data registers carry no meaning while their valid bit
        // is clear, so they are left without reset.
        if (k == STAGES - 1) begin : g_out_data
            always_ff @(posedge clk_i) begin
                if (!resetn_i) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                end else if (w_en) begin
                    r_sum  <= w_sum_next;
                    r_cout <= w_chunk_sum[CHUNK];
                end
            end
        end else begin : g_mid_data
            always_ff @(posedge clk_i) begin
                if (w_en) begin
                    r_sum  <= w_sum_next;
                    r_cout <= w_chunk_sum[CHUNK];
                end
            end
        end

        // Operand bits above this stage's chunk travel on to the next stage,
        // shifted down so the next chunk sits at bit 0.
        if (k < STAGES - 1) begin : g_fwd
            logic [SRC_W-CHUNK-1:0] r_a;
            logic [SRC_W-CHUNK-1:0] r_b;
`ifdef PIPE_ADDER_SUB_EN
            logic                   r_sub;
`endif

            always_ff @(posedge clk_i) begin
                if (w_en) begin
                    r_a   <= w_a_src[SRC_W-1:CHUNK];
                    r_b   <= w_b_src[SRC_W-1:CHUNK];
`ifdef PIPE_ADDER_SUB_EN
                    r_sub <= w_sub_in;
`endif
                end
            end
        end
    end

    assign out_valid_o = g_stage[STAGES-1].r_valid;
    assign sum_o       = g_stage[STAGES-1].r_sum;
    assign cout_o      = g_stage[STAGES-1].r_cout;

endmodule

// File: tb/tb_day3_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_day3_pipelined_adder
//
// Self-checking bench for day3_pipelined_adder (WIDTH=16, STAGES=4).
// A directed vector table, hand-written reset/stall sequences and a random
// stream are checked against an arithmetic reference model and a queue of
// expected results in acceptance order.
// -----------------------------------------------------------------------------
module tb_day3_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk_i;
    logic             resetn_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_v;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;

    day3_pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
`ifdef PIPE_ADDER_SUB_EN
        .sub_i       (sub_v),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH:0] exp;
        int             acc_cyc;
    } sb_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    sb_t              sb[$];
    vec_t             tbl[10];
    int               n_tbl;
    int               n_cmp;
    int               n_bad;
    int               cyc;
    logic             exact_lat;
    logic             use_tbl;
    logic [WIDTH:0]   tbl_exp;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_cout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operands.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
        int unsigned bv;
        int unsigned r;
        bv = sub ? ((~int'(b)) & 32'hFFFF) : int'(b);
        r  = int'(a) + bv + int'(cin);
        return r[WIDTH:0];
    endfunction

    // Evaluated mid-cycle, once inputs and DUT outputs have settled.
    task automatic monitor();
        if (!resetn_i) begin
            check("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
            hold_valid = 1'b0;
            return;
        end
        if (hold_valid) begin
            check("stall_out_valid", {31'b0, out_valid_o}, 32'd1);
            check("stall_sum_stable", {16'b0, sum_o}, {16'b0, hold_sum});
            check("stall_cout_stable", {31'b0, cout_o}, {31'b0, hold_cout});
        end
        if (out_valid_o && !out_ready_i) begin
            check("stall_in_ready", {31'b0, in_ready_o}, 32'd0);
        end
        if (!out_valid_o) begin
            check("free_in_ready", {31'b0, in_ready_o}, 32'd1);
        end
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {31'b0, out_valid_o}, 32'd0);
            end else begin
                sb_t e;
                int  lat;
                e   = sb.pop_front();
                lat = cyc - e.acc_cyc;
                check("sum", {16'b0, sum_o}, {16'b0, e.exp[WIDTH-1:0]});
                check("cout", {31'b0, cout_o}, {31'b0, e.exp[WIDTH]});
                if (exact_lat) check("latency", lat, STAGES);
                else           check("latency_min", {31'b0, (lat >= STAGES)}, 32'd1);
            end
        end
        if (in_valid_i && in_ready_o) begin
            sb_t n;
            n.exp     = use_tbl ? tbl_exp : model(a_i, b_i, cin_i, sub_v);
            n.acc_cyc = cyc;
            sb.push_back(n);
        end
        hold_valid = out_valid_o && !out_ready_i;
        hold_sum   = sum_o;
        hold_cout  = cout_o;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s, input logic r);
        in_valid_i  = v;
        a_i         = a;
        b_i         = b;
        cin_i       = c;
        sub_v       = s;
        out_ready_i = r;
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Bounded drain: every expected beat must come out within the budget.
    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !out_valid_o) break;
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        check("drain_empty", sb.size(), 32'd0);
        sb.delete();
        idle(3);
    endtask

    task automatic send_const(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic c, input logic s,
                              input logic [WIDTH-1:0] es, input logic ec);
        use_tbl = 1'b1;
        tbl_exp = {ec, es};
        drive(1'b1, a, b, c, s, 1'b1);
        use_tbl = 1'b0;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        exact_lat = 1'b1; use_tbl = 1'b0; tbl_exp = '0;
        hold_valid = 1'b0; hold_sum = '0; hold_cout = 1'b0;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0};
        tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0};
        tbl[7] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0};
        n_tbl  = 8;
`ifdef PIPE_ADDER_SUB_EN
        tbl[8] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
        tbl[9] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1};
        n_tbl  = 10;
`endif

        // Reset held for three cycles with in_valid_i asserted.
        resetn_i = 1'b0; in_valid_i = 1'b1; a_i = 16'h1234; b_i = 16'h1111;
        cin_i = 1'b1; sub_v = 1'b0; out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(i * 16'h1111), 16'hFFFF, 1'b1, 1'b0, 1'b1);
            check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
            check("rst_sum", {16'b0, sum_o}, 32'd0);
            check("rst_cout", {31'b0, cout_o}, 32'd0);
            check("rst_in_ready_q", {31'b0, in_ready_o}, 32'd0);
        end
        resetn_i = 1'b1;
        idle(2);

        // Directed vectors, one beat at a time, exact latency.
        for (int i = 0; i < n_tbl; i++) begin
            send_const(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sum, tbl[i].cout);
        end

        // Eight back-to-back beats, no stall.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            drive(1'b1, 16'(i * 16'h1111), 16'(i), iv[0], 1'b0, 1'b1);
        end
        drain();

        // Stream with the output stalled for five cycles in the middle.
        exact_lat = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0,
                  !(i >= 6 && i < 11));
        end
        drain();

        // Two beats in flight, then a one-cycle reset: both must vanish.
        exact_lat = 1'b1;
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h0101, 16'h0202, 1'b1, 1'b0, 1'b1);
        resetn_i = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        resetn_i = 1'b1;
        sb.delete();
        check("rst_mid_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_mid_sum", {16'b0, sum_o}, 32'd0);
        idle(8);
        send_const(16'h4000, 16'hC000, 1'b1, 1'b0, 16'h0001, 1'b1);

        // Random traffic with random back-pressure.
        exact_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic s;
`ifdef PIPE_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 1'($urandom), s,
                  $urandom_range(0, 9) < 6);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
